// File: rtl/vz_mem_inject.sv
// VZ snapshot loader back end: buffers loader byte writes and injects them into
// main RAM while holding the Z80 off the bus via BUSREQ/BUSACK.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | bus belongs to the CPU, waiting for buffered bytes
// REQ     | busreq raised, waiting for busack
// SETUP   | address/data of the FIFO head presented, no strobe yet
// WRITE   | ram_we pulse for the presented byte, entry popped
// HOLD    | FIFO empty but loader still busy, keep the bus
// RELEASE | busreq dropped, waiting for the CPU to take the bus back
module vz_mem_inject #(
  parameter int unsigned DEPTH  = 8,
  parameter logic [15:0] RAM_LO = 16'h7800,
  parameter logic [15:0] RAM_HI = 16'hB7FF
) (
  input  logic                     I_CLK,
  input  logic                     I_RST,
  input  logic                     ld_wr,
  input  logic [15:0]              ld_addr,
  input  logic [7:0]               ld_data,
  input  logic                     ld_busy,
  input  logic                     cpu_busack,
  output logic                     cpu_busreq,
  output logic [15:0]              ram_addr,
  output logic [7:0]               ram_data,
  output logic                     ram_we,
  output logic                     active,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_SETUP, S_WRITE, S_HOLD, S_RELEASE
  } state_t;

  state_t        state, state_nxt;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_inc;
  logic [LW-1:0] level_nxt;
  logic          in_win, full, push, pop, drop;
  logic          busreq_d, we_d, active_d, load_d;
  logic [23:0]   head_d;

  assign in_win     = (ld_addr >= RAM_LO) && (ld_addr <= RAM_HI);
  assign full       = (fifo_level == LW'(DEPTH));
  assign push       = ld_wr && in_win && !full;
  assign drop       = ld_wr && !in_win;
  // a write only retires if the bus was still granted while strobing
  assign pop        = (state == S_WRITE) && cpu_busack;
  assign rd_ptr_inc = rd_ptr + AW'(1);
  assign level_nxt  = fifo_level + LW'(push) - LW'(pop);

  always_ff @(posedge I_CLK) begin
    if (push) mem[wr_ptr] <= {ld_addr, ld_data};
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      fifo_level <= level_nxt;
      if (ld_wr && in_win && full) overflow <= 1'b1;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state      <= S_IDLE;
      cpu_busreq <= 1'b0;
      ram_we     <= 1'b0;
      active     <= 1'b0;
      ram_addr   <= 16'h0000;
      ram_data   <= 8'h00;
    end else begin
      state      <= state_nxt;
      cpu_busreq <= busreq_d;
      ram_we     <= we_d;
      active     <= active_d;
      if (load_d) {ram_addr, ram_data} <= head_d;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (fifo_level != '0) state_nxt = S_REQ;
      S_REQ:     if (cpu_busack) state_nxt = S_SETUP;
      S_SETUP:   state_nxt = cpu_busack ? S_WRITE : S_REQ;
      S_WRITE: begin
        if (!cpu_busack)           state_nxt = S_REQ;
        else if (level_nxt != '0)  state_nxt = S_SETUP;
        else if (ld_busy)          state_nxt = S_HOLD;
        else                       state_nxt = S_RELEASE;
      end
      S_HOLD: begin
        if (!cpu_busack)           state_nxt = S_REQ;
        else if (fifo_level != '0) state_nxt = S_SETUP;
        else if (!ld_busy)         state_nxt = S_RELEASE;
      end
      S_RELEASE: if (!cpu_busack) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so the registered copies line up with it
  always_comb begin
    busreq_d = 1'b0;
    we_d     = 1'b0;
    active_d = 1'b0;
    load_d   = 1'b0;
    head_d   = mem[rd_ptr];
    unique case (state_nxt)
      S_REQ:   busreq_d = 1'b1;
      S_SETUP: begin busreq_d = 1'b1; active_d = 1'b1; load_d = 1'b1; end
      S_WRITE: begin busreq_d = 1'b1; active_d = 1'b1; we_d = 1'b1; end
      S_HOLD:  begin busreq_d = 1'b1; active_d = 1'b1; end
      default: ;
    endcase
    // after a pop the head moves on; with one entry left it is the byte being pushed now
    if (pop) head_d = (fifo_level == LW'(1)) ? {ld_addr, ld_data} : mem[rd_ptr_inc];
  end

endmodule

// File: doc/vz_mem_inject.md
# vz_mem_inject

Downstream stage of the VZ snapshot loader: it accepts the loader's byte-write strobes (addr/data pairs), buffers them in a small FIFO, and writes them into the Laser310 main RAM. It takes the RAM off the Z80 with a BUSREQ/BUSACK handshake, so program bytes and the post-load BASIC/mcode pointer patches land in memory without colliding with CPU cycles. Writes outside the RAM window are filtered and counted.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- RAM_LO, 16'h7800, lowest writable address (inclusive)
- RAM_HI, 16'hB7FF, highest writable address (inclusive)

Ports (one clock; reset is synchronous and active-high, named I_CLK / I_RST as elsewhere in the codebase):
- I_CLK  in  1  system clock
- I_RST  in  1  synchronous active-high reset
- ld_wr  in  1  one-cycle strobe: capture ld_addr/ld_data
- ld_addr  in  16  target address
- ld_data  in  8  byte to write
- ld_busy  in  1  loader still producing bytes (download or finish phase)
- cpu_busack  in  1  CPU has released the bus (active-high, already inverted)
- cpu_busreq  out  1  request CPU bus release (active-high)
- ram_addr  out  16  RAM write address
- ram_data  out  8  RAM write data
- ram_we  out  1  RAM write enable, one cycle per byte
- active  out  1  block currently owns the RAM port
- fifo_level  out  $clog2(DEPTH)+1  current entry count
- overflow  out  1  sticky: a write was lost because the FIFO was full
- drop_cnt  out  8  saturating count of out-of-window writes

## Operation
- Push: on ld_wr with RAM_LO <= ld_addr <= RAM_HI and FIFO not full, store {ld_addr, ld_data}. Out-of-window: not stored, drop_cnt += 1, saturating at 255. Full FIFO with an in-window write: not stored, overflow <= 1; it clears only on reset.
- Pop occurs only in WRITE. A push and a pop in the same cycle leave the level unchanged; the pushed entry is kept.
- States:
  - IDLE: busreq=0, we=0. Go to REQ if the FIFO is non-empty.
  - REQ: busreq=1. Go to SETUP when cpu_busack=1.
  - SETUP: busreq=1. ram_addr/ram_data = FIFO head, we=0. Go to WRITE.
  - WRITE: ram_we=1 with the same addr/data; pop. Then go to SETUP if entries remain after the pop (including a same-cycle push). Otherwise go to HOLD if ld_busy, else RELEASE.
  - HOLD: busreq=1, we=0. Go to SETUP if the FIFO is non-empty; else go to RELEASE if ld_busy=0.
  - RELEASE: busreq=0. Go to IDLE when cpu_busack=0.
- active=1 in SETUP, WRITE and HOLD.
- cpu_busack dropping outside REQ/RELEASE is a protocol error. The FSM goes to REQ, abandons no entry, and never asserts ram_we without busack=1.
- ram_addr/ram_data hold their last values when not writing. ram_we must never be 1 outside WRITE.

## Timing
- Reset values: cpu_busreq=0, ram_we=0, ram_addr=0, ram_data=0, active=0, fifo_level=0, overflow=0, drop_cnt=0, state IDLE. FIFO pointers are cleared; contents are don't-care.
- Reset mid-write: the next cycle has ram_we=0 and busreq=0, and pending entries are discarded.
- All outputs are registered.
- Latency from an ld_wr into an empty FIFO with busack already high:
  - busreq rises at ld_wr+2.
  - SETUP begins the cycle after busack is sampled high.
  - ram_we occurs 1 cycle after SETUP.
- Sustained throughput: 1 byte per 2 cycles while the bus is held.
- Bus release: busreq falls 1 cycle after the last WRITE when ld_busy=0, or 1 cycle after ld_busy falls in HOLD.
- The loader must not burst faster than 1 byte per 2 cycles for longer than DEPTH bytes. Violations set overflow.

## Test plan
- Single byte: ld_wr addr 16'h7AE9 data 8'h55, busack follows busreq after 3 cycles → exactly one ram_we with 7AE9/55, then busreq drops and active=0.
- Burst of 8 back-to-back strobes (addr 7800..7807, data 00..07), busack immediate, ld_busy high → 8 writes in order at 2-cycle spacing. overflow stays 0 because the FIFO drains. The bus is held in HOLD until ld_busy falls.
- Busack withheld while 9 in-window strobes arrive (DEPTH=8) → fifo_level=8, overflow=1, and the first 8 bytes are written after busack.
- Out-of-window writes to 16'h0000 and 16'hC000 → no push, drop_cnt=2, no busreq.
- Same-cycle push and pop in WRITE → fifo_level unchanged, FSM goes to SETUP, and no byte is lost or duplicated.
- I_RST asserted in SETUP with 4 entries pending → the next cycle has busreq=0, ram_we=0, fifo_level=0, and no writes follow.
